serial_alu_ctrl: RTL and testbench

Bit-serial sequencer that computes a WIDTH-bit ALU operation by driving one ALU_1bit slice once per clock, LSB first.
- Carry is chained through an internal register between bits.
- Accepts a start/operand handshake, shifts operands into the slice and collects result bits.
- Reports result, final carry-out and zero flag with a one-cycle done pulse.
- Sits between the register/control logic and the shared 1-bit ALU slice.

---
 rtl/alu_defs_pkg.sv | 19 +
 rtl/alu_1bit.sv | 39 +++
 rtl/serial_alu_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the bit-serial ALU: slice opcodes and controller state encoding.
package alu_defs;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;
  localparam logic [2:0] OP_NOTA  = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_1bit.sv
// Shared 1-bit ALU slice; carry-in/out make add/sub chain across serial bits.
module ALU_1bit
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] s,
  output logic       out,
  output logic       cout
);

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    case (s)
      OP_AND:   out = a & b;
      OP_OR:    out = a | b;
      OP_XOR:   out = a ^ b;
      OP_ADD: begin
        out  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      // Subtract is a + ~b + cin; callers set cin=1 for two's complement.
      OP_SUB: begin
        out  = a ^ ~b ^ cin;
        cout = (a & ~b) | (cin & (a ^ ~b));
      end
      OP_PASSA: out = a;
      OP_NOTA:  out = ~a;
      OP_PASSB: out = b;
      default: begin
        out  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: feeds one ALU slice LSB first, chains carry through a register,
// and assembles a WIDTH-bit result with carry-out, zero flag and a one-cycle done pulse.
module serial_alu_ctrl
  import alu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_s,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q,     op_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             zero_q,   zero_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    res_next = {slice_out, res_sh_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over the bit capture of the same edge.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          res_sh_d = res_next;
          carry_d  = slice_cout;
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            result_d = res_next;
            cout_d   = slice_cout;
            zero_d   = (res_next == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign slice_a   = a_sh_q[0];
  assign slice_b   = b_sh_q[0];
  assign slice_cin = carry_q;
  assign slice_s   = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench: controller plus a real slice, hand-computed results and timing.
module tb_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, cin;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       slice_a, slice_b, slice_cin, slice_out, slice_cout;
  logic [2:0] slice_s;
  logic       busy, done, cout, zero;
  logic [7:0] result;

  int n_pass  = 0;
  int n_total = 0;
  int lat, busy_cnt, pulses, first_t, second_t, third_t;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .a(a), .b(b), .cin(cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_s(slice_s),
    .slice_out(slice_out), .slice_cout(slice_cout),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  ALU_1bit u_slice (
    .a(slice_a), .b(slice_b), .cin(slice_cin), .s(slice_s),
    .out(slice_out), .cout(slice_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [2:0] vop);
    a = va; b = vb; cin = vc; op = vop; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; op = 3'b000;
  endtask

  // Counts edges after the launch edge until done, bounded.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cin = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_cout", cout, 0);
    chk("rst_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 5A + 33 = 8D
    launch(8'h5A, 8'h33, 1'b0, 3'b011);
    chk("t1_busy_after_start", busy, 1);
    chk("t1_slice_s", slice_s, 3'b011);
    wait_done(lat, busy_cnt);
    chk("t1_latency", lat, 8);
    chk("t1_busy_cycles", busy_cnt, 8);
    chk("t1_result", result, 8'h8D);
    chk("t1_cout", cout, 0);
    chk("t1_zero", zero, 0);
    tick();
    chk("t1_done_one_cycle", done, 0);
    tick();

    // Abort of 0F + 01: result keeps 8D, no done
    launch(8'h0F, 8'h01, 1'b0, 3'b011);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy_dropped", busy, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("t4_no_done", pulses, 0);
    chk("t4_result_held", result, 8'h8D);
    launch(8'h0F, 8'h01, 1'b0, 3'b011);
    wait_done(lat, busy_cnt);
    chk("t4_restart_result", result, 8'h10);
    tick(); tick();

    // FF + 01, cin 0 and 1
    launch(8'hFF, 8'h01, 1'b0, 3'b011);
    wait_done(lat, busy_cnt);
    chk("t2a_result", result, 8'h00);
    chk("t2a_cout", cout, 1);
    chk("t2a_zero", zero, 1);
    tick(); tick();
    launch(8'hFF, 8'h01, 1'b1, 3'b011);
    wait_done(lat, busy_cnt);
    chk("t2b_result", result, 8'h01);
    chk("t2b_cout", cout, 1);
    chk("t2b_zero", zero, 0);
    tick(); tick();

    // start mid-run ignored
    launch(8'h10, 8'h20, 1'b0, 3'b011);
    tick(); tick();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00;
    wait_done(lat, busy_cnt);
    chk("t3_latency", lat, 5);
    chk("t3_result", result, 8'h30);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("t3_single_done", pulses, 0);

    // XOR: carry register stays clear
    launch(8'h5A, 8'h33, 1'b0, 3'b010);
    wait_done(lat, busy_cnt);
    chk("xor_result", result, 8'h69);
    chk("xor_cout", cout, 0);
    tick(); tick();

    // Async reset mid-run
    launch(8'h7F, 8'h01, 1'b0, 3'b011);
    tick(); tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_result", result, 8'h00);
    chk("t5_cout", cout, 0);
    chk("t5_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    launch(8'h01, 8'h01, 1'b0, 3'b011);
    wait_done(lat, busy_cnt);
    chk("t5_after_result", result, 8'h02);
    chk("t5_after_zero", zero, 0);
    tick(); tick();

    // Back-to-back with start held high
    a = 8'h03; b = 8'h04; cin = 1'b0; op = 3'b011; start = 1'b1;
    pulses = 0; first_t = -1; second_t = -1; third_t = -1;
    for (int t = 1; t <= 35; t++) begin
      tick();
      if (done) begin
        pulses++;
        if (first_t < 0) first_t = t;
        else if (second_t < 0) second_t = t;
        else if (third_t < 0) third_t = t;
      end
    end
    start = 1'b0;
    chk("t6_pulses", pulses, 3);
    chk("t6_first", first_t, 9);
    chk("t6_period1", second_t - first_t, 10);
    chk("t6_period2", third_t - second_t, 10);
    chk("t6_result", result, 8'h07);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
